regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 register file. It shares the single write port between the core's single-cycle writeback and the multi-cycle multiply/divide unit (MDU). It tracks which registers have an MDU result in flight and raises a stall on any read-after-write or write-after-write hazard. It sits between the core/MDU result paths and `regfile` (`reg_write`, `rd`, `wd`).

## Interface
Parameters:
- `XLEN`, 32, data width
- `STARVE_LIMIT`, 4, consecutive lost-arbitration cycles before MDU is forced ahead of core (≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `wb_valid`  in  1  core writeback request
- `wb_rd`  in  5  core destination
- `wb_data`  in  XLEN  core result
- `mdu_issue`  in  1  MDU op accepted this cycle
- `mdu_issue_rd`  in  5  its destination
- `mdu_valid`  in  1  MDU result ready
- `mdu_rd`  in  5  MDU destination
- `mdu_data`  in  XLEN  MDU result
- `mdu_ready`  out  1  MDU result accepted (handshake completes on `mdu_valid && mdu_ready` at clock edge)
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  decode-stage operands to check
- `stall`  out  1  freeze fetch/decode/writeback
- `rf_we`  out  1  to regfile `reg_write`
- `rf_rd`  out  5  to regfile `rd`
- `rf_wd`  out  XLEN  to regfile `wd`
- `busy_vec`  out  32  scoreboard bits (debug)

## Operation
- A request with rd = 0 is not a request. It is never granted and never marked busy.
- Core request `creq = wb_valid && wb_rd != 0`. MDU request `mreq = mdu_valid && mdu_rd != 0`. `mdu_valid` with `mdu_rd = 0` gets `mdu_ready = 1` immediately, with no write.
- FSM has 2 states:
  - NORMAL:
    - `creq` is granted.
    - If `!creq`, `mreq` is granted.
    - If both request, core wins and `wait_cnt` increments.
    - When `wait_cnt == STARVE_LIMIT-1` and the MDU loses again, the FSM moves to FORCE_MDU.
  - FORCE_MDU:
    - MDU is granted.
    - If `creq`, `core_stall = 1`. The core holds `wb_*` stable.
    - On the MDU handshake, the FSM returns to NORMAL and `wait_cnt` clears.
- An MDU grant in NORMAL also clears `wait_cnt`.
- Granted source drives `rf_we = 1`, `rf_rd`, `rf_wd`. With no grant, `rf_we = 0`, `rf_rd = 0`, `rf_wd = 0`.
- Scoreboard:
  - `mdu_issue` with nonzero rd sets `busy[rd]`.
  - An MDU handshake clears `busy[mdu_rd]`.
  - If set and clear target the same register in the same cycle, set wins.
- `hazard` is asserted when any nonzero `id_rs1`, `id_rs2` or `id_rd` has its busy bit set.
- `stall = hazard || core_stall`.
- `wait_cnt` width is `$clog2(STARVE_LIMIT)`, minimum 1. It saturates and never wraps.

## Timing
- `rf_*`, `mdu_ready`, `stall`: combinational from inputs and state. The regfile commits at the next rising edge, so write latency is 0 cycles to the edge.
- `busy_vec`, FSM state, `wait_cnt`: registered.
- Busy bit visible the cycle after `mdu_issue`.
- Reset (asynchronous, any time, including mid-handshake or in FORCE_MDU):
  - `busy_vec = 0`, state NORMAL, `wait_cnt = 0`.
  - While `rst_n` is low, `rf_we = 0`, `mdu_ready = 0`, `stall = 0`.
  - An in-flight MDU result is dropped. The MDU must be reset by the same `rst_n`.
- Worst-case MDU wait is `STARVE_LIMIT` cycles. Worst-case core stall is 1 cycle per forced grant.

## Configuration
- `REGFILE_ARB_BYPASS_EN` defined:
  - The busy bit of the register being written by the MDU this cycle is masked from `hazard`. A dependent instruction proceeds in the handshake cycle.
  - Adds outputs `byp_rs1_hit`, `byp_rs2_hit` (1 bit each) so the core muxes `mdu_data` onto its operand.
- Undefined: `hazard` uses registered `busy_vec` only. The dependent instruction stalls through the handshake cycle and proceeds one cycle later. Bypass ports are absent.

## Structure
- Package `regfile_arb_pkg`:
  - `arb_state_t` (NORMAL, FORCE_MDU)
  - `REG_ADDR_W = 5`
  - `NUM_REGS = 32`
  - `XLEN` default
- One sub-module `regfile_scoreboard`: busy vector set/clear plus 3-port hazard compare (with optional bypass mask). Arbitration FSM and mux stay in the top.

## Test plan
- Core only, wb x3 = 0x11, then wb x0 = 0x22 → `rf_we = 1`/x3/0x11, then `rf_we = 0`; regfile x0 stays 0.
- Issue MDU to x5, next cycle `id_rs1 = 5` → `stall = 1` until handshake. Without macro, `stall` drops the cycle after the handshake; with macro, it drops in the handshake cycle and `byp_rs1_hit = 1`.
- `creq` and `mreq` every cycle, STARVE_LIMIT = 4:
  - core granted 4 cycles;
  - cycle 5 MDU granted with `stall = 1`;
  - cycle 6 core granted; `wait_cnt = 0`.
- Same-cycle MDU handshake on x7 and new `mdu_issue` to x7 → `busy_vec[7]` remains 1.
- `rst_n` low while in FORCE_MDU with `busy_vec = 0x0000_00A0` → immediately `busy_vec = 0`, `rf_we = 0`, `stall = 0`; after release, state NORMAL.
- `mdu_valid` with `mdu_rd = 0` → `mdu_ready = 1`, `rf_we = 0`, no busy change.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
// Shared types and constants for the register-file write-port arbiter.
//   arb_state_t  : arbitration FSM states (NORMAL, FORCE_MDU)
//   REG_ADDR_W   : register address width (5)
//   NUM_REGS     : number of architectural registers (32)
//   DEFAULT_XLEN : default datapath width (32)
//   cnt_width()  : width of the starvation counter for a given limit
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int DEFAULT_XLEN = 32;

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_MDU = 1'b1
  } arb_state_t;

  // A limit of 1 would give $clog2 == 0; the counter always keeps at least one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Busy-bit scoreboard for registers that have an MDU result in flight, plus
// the decode-stage hazard compare on rs1/rs2/rd.
//   clk, rst_n         : clock, asynchronous active-low reset
//   set_en, set_rd     : MDU issue; marks set_rd busy (rd 0 ignored)
//   clr_en, clr_rd     : MDU handshake; clears clr_rd
//   id_rs1/id_rs2/id_rd: decode operands to check
//   byp_rs1_hit/rs2_hit: (REGFILE_ARB_BYPASS_EN only) operand matches the
//                        register the MDU is writing this cycle
//   busy_vec           : registered busy bits
//   hazard             : some nonzero operand is busy
// Optional feature macro: REGFILE_ARB_BYPASS_EN
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
`ifdef REGFILE_ARB_BYPASS_EN
  output logic                  byp_rs1_hit,
  output logic                  byp_rs2_hit,
`endif
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_eff;

  // Clear is applied before set so a same-cycle reissue to the same register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != '0)) begin
      busy_d[set_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // With bypass, the register being written by the MDU right now is not a hazard:
  // the core takes mdu_data directly instead of waiting for the regfile.
  always_comb begin
    busy_eff = busy_q;
`ifdef REGFILE_ARB_BYPASS_EN
    if (clr_en && (clr_rd != '0)) begin
      busy_eff[clr_rd] = 1'b0;
    end
`endif
  end

`ifdef REGFILE_ARB_BYPASS_EN
  assign byp_rs1_hit = clr_en && (clr_rd != '0) && (id_rs1 == clr_rd);
  assign byp_rs2_hit = clr_en && (clr_rd != '0) && (id_rs2 == clr_rd);
`endif

  assign hazard = ((id_rs1 != '0) && busy_eff[id_rs1]) ||
                  ((id_rs2 != '0) && busy_eff[id_rs2]) ||
                  ((id_rd  != '0) && busy_eff[id_rd]);

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single regfile write port between the core writeback path and
// the multi-cycle MDU. Core normally wins; after STARVE_LIMIT consecutive
// losses the MDU is forced ahead for one grant while the core is stalled.
// A scoreboard tracks in-flight MDU destinations and raises RAW/WAW stalls.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   wb_valid/wb_rd/wb_data         : core writeback request
//   mdu_issue/mdu_issue_rd         : MDU op accepted (marks rd busy)
//   mdu_valid/mdu_rd/mdu_data      : MDU result; mdu_ready completes handshake
//   id_rs1/id_rs2/id_rd            : decode-stage operands
//   stall                          : freeze fetch/decode/writeback
//   rf_we/rf_rd/rf_wd              : regfile write port
//   byp_rs1_hit/byp_rs2_hit        : (REGFILE_ARB_BYPASS_EN only) operand
//                                    should take mdu_data this cycle
//   busy_vec                       : scoreboard bits (debug)
// Optional feature macro: REGFILE_ARB_BYPASS_EN
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int XLEN         = DEFAULT_XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  mdu_issue,
  input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]       mdu_data,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output logic                  stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wd,
`ifdef REGFILE_ARB_BYPASS_EN
  output logic                  byp_rs1_hit,
  output logic                  byp_rs2_hit,
`endif
  output logic [NUM_REGS-1:0]   busy_vec
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic creq, mreq;
  logic grant_core, grant_mdu;
  logic core_stall;
  logic hazard;
  logic mdu_hs;

  assign creq   = wb_valid  && (wb_rd  != '0);
  assign mreq   = mdu_valid && (mdu_rd != '0);
  assign mdu_hs = mdu_valid && mdu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NORMAL;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Arbitration: core has priority until the MDU has lost STARVE_LIMIT times in a row.
  // An MDU result with rd 0 is acknowledged at once without touching the regfile.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    grant_core = 1'b0;
    grant_mdu  = 1'b0;
    core_stall = 1'b0;

    case (state_q)
      NORMAL: begin
        if (creq) begin
          grant_core = 1'b1;
          if (mreq) begin
            if (wait_cnt_q == CNT_LAST) begin
              state_d = FORCE_MDU;
            end
            if (wait_cnt_q != CNT_MAX) begin
              wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
          end
        end else if (mreq) begin
          grant_mdu  = 1'b1;
          wait_cnt_d = '0;
        end
      end
      FORCE_MDU: begin
        grant_mdu  = mreq;
        core_stall = creq;
      end
      default: begin
        state_d = NORMAL;
      end
    endcase

    mdu_ready = rst_n && (grant_mdu || (mdu_valid && (mdu_rd == '0)));

    if ((state_q == FORCE_MDU) && mdu_valid && mdu_ready) begin
      state_d    = NORMAL;
      wait_cnt_d = '0;
    end

    rf_we = rst_n && (grant_core || grant_mdu);
    rf_rd = '0;
    rf_wd = '0;
    if (rf_we) begin
      if (grant_core) begin
        rf_rd = wb_rd;
        rf_wd = wb_data;
      end else begin
        rf_rd = mdu_rd;
        rf_wd = mdu_data;
      end
    end
  end

  assign stall = rst_n && (hazard || core_stall);

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en      (mdu_issue),
    .set_rd      (mdu_issue_rd),
    .clr_en      (mdu_hs),
    .clr_rd      (mdu_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
`ifdef REGFILE_ARB_BYPASS_EN
    .byp_rs1_hit (byp_rs1_hit),
    .byp_rs2_hit (byp_rs2_hit),
`endif
    .busy_vec    (busy_vec),
    .hazard      (hazard)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench for regfile_wb_arbiter (STARVE_LIMIT = 4). Expected
// regfile writes are queued as stimulus is driven and popped when the DUT
// asserts rf_we. Handles both builds of REGFILE_ARB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] busy_vec;
`ifdef REGFILE_ARB_BYPASS_EN
  logic        byp_rs1_hit, byp_rs2_hit;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;

  wr_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mdu_issue    (mdu_issue),
    .mdu_issue_rd (mdu_issue_rd),
    .mdu_valid    (mdu_valid),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .stall        (stall),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wd        (rf_wd),
`ifdef REGFILE_ARB_BYPASS_EN
    .byp_rs1_hit  (byp_rs1_hit),
    .byp_rs2_hit  (byp_rs2_hit),
`endif
    .busy_vec     (busy_vec)
  );

  // Drives every input to its idle value.
  task automatic idle_inputs();
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    mdu_issue = 1'b0; mdu_issue_rd = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
  endtask

  // Reset asserted with live requests: nothing may leak out.
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    wb_valid = 1'b1; wb_rd = 5'd3; mdu_valid = 1'b1; mdu_rd = 5'd4;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rf_we got %b want 0", rf_we); end
    vectors++; if (mdu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mdu_ready got %b want 0", mdu_ready); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b want 0", stall); end
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_busy got %h want 0", busy_vec); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Core writes x3, then an x0 request that must be ignored.
  task automatic test_core_write();
    wr_t e;
    @(negedge clk);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    exp_q.push_back('{rd: 5'd3, wd: 32'h11});
    #1;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("[TB] FAIL core_we got %b want 1", rf_we); end
    if (rf_we === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rf_rd !== e.rd || rf_wd !== e.wd) begin
        miscompares++; $display("[TB] FAIL core_write got x%0d=%h want x%0d=%h", rf_rd, rf_wd, e.rd, e.wd);
      end
    end
    @(negedge clk);
    wb_rd = 5'd0; wb_data = 32'h22;
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("[TB] FAIL x0_we got %b want 0", rf_we); end
    vectors++; if (rf_rd !== 5'd0 || rf_wd !== 32'h0) begin miscompares++; $display("[TB] FAIL x0_port got x%0d=%h want x0=0", rf_rd, rf_wd); end
    idle_inputs();
  endtask

  // MDU issue to x5 then a dependent read of x5.
  task automatic test_hazard();
    wr_t e;
    logic exp_hs_stall;
`ifdef REGFILE_ARB_BYPASS_EN
    exp_hs_stall = 1'b0;
`else
    exp_hs_stall = 1'b1;
`endif
    @(negedge clk);
    mdu_issue = 1'b1; mdu_issue_rd = 5'd5;
    #1;
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("[TB] FAIL busy_early got %h want 0", busy_vec); end
    @(negedge clk);
    mdu_issue = 1'b0; mdu_issue_rd = '0; id_rs1 = 5'd5;
    #1;
    vectors++; if (busy_vec !== 32'h20) begin miscompares++; $display("[TB] FAIL busy_set got %h want 00000020", busy_vec); end
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL raw_stall got %b want 1", stall); end
    @(negedge clk);
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL raw_stall_hold got %b want 1", stall); end
    @(negedge clk);
    mdu_valid = 1'b1; mdu_rd = 5'd5; mdu_data = 32'h55;
    exp_q.push_back('{rd: 5'd5, wd: 32'h55});
    #1;
    vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL hs_ready got %b want 1", mdu_ready); end
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("[TB] FAIL hs_we got %b want 1", rf_we); end
    if (rf_we === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rf_rd !== e.rd || rf_wd !== e.wd) begin
        miscompares++; $display("[TB] FAIL hs_write got x%0d=%h want x%0d=%h", rf_rd, rf_wd, e.rd, e.wd);
      end
    end
    vectors++; if (stall !== exp_hs_stall) begin miscompares++; $display("[TB] FAIL hs_stall got %b want %b", stall, exp_hs_stall); end
`ifdef REGFILE_ARB_BYPASS_EN
    vectors++; if (byp_rs1_hit !== 1'b1) begin miscompares++; $display("[TB] FAIL byp_rs1 got %b want 1", byp_rs1_hit); end
`endif
    @(negedge clk);
    mdu_valid = 1'b0; mdu_rd = '0;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL post_hs_stall got %b want 0", stall); end
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("[TB] FAIL busy_clear got %h want 0", busy_vec); end
    idle_inputs();
  endtask

  // Contention: 2 core wins, an MDU-only grant (counter clears), then two full starvation rounds.
  task automatic test_starvation();
    wr_t e;
    logic       wb_on   [14] = '{1,1,0,1,1,1,1,1,1,1,1,1,1,1};
    logic       exp_mdu [14] = '{0,0,1,0,0,0,0,1,0,0,0,0,1,0};
    logic       exp_stl [14] = '{0,0,0,0,0,0,0,1,0,0,0,0,1,0};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      wb_valid  = wb_on[i]; wb_rd  = 5'd9;  wb_data  = 32'hA000 + i;
      mdu_valid = 1'b1;     mdu_rd = 5'd10; mdu_data = 32'hB000 + i;
      if (exp_mdu[i]) exp_q.push_back('{rd: 5'd10, wd: 32'hB000 + i});
      else            exp_q.push_back('{rd: 5'd9,  wd: 32'hA000 + i});
      #1;
      vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("[TB] FAIL starve_we[%0d] got %b want 1", i, rf_we); end
      if (rf_we === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (rf_rd !== e.rd || rf_wd !== e.wd) begin
          miscompares++; $display("[TB] FAIL starve_write[%0d] got x%0d=%h want x%0d=%h", i, rf_rd, rf_wd, e.rd, e.wd);
        end
      end
      vectors++; if (mdu_ready !== exp_mdu[i]) begin miscompares++; $display("[TB] FAIL starve_ready[%0d] got %b want %b", i, mdu_ready, exp_mdu[i]); end
      vectors++; if (stall !== exp_stl[i]) begin miscompares++; $display("[TB] FAIL starve_stall[%0d] got %b want %b", i, stall, exp_stl[i]); end
    end
    exp_q.delete();
    idle_inputs();
  endtask

  // Handshake on x7 in the same cycle as a new issue to x7: set wins.
  task automatic test_same_cycle();
    wr_t e;
    @(negedge clk);
    mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
    @(negedge clk);
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
    exp_q.push_back('{rd: 5'd7, wd: 32'h77});
    #1;
    vectors++; if (busy_vec !== 32'h80) begin miscompares++; $display("[TB] FAIL same_busy_pre got %h want 00000080", busy_vec); end
    if (rf_we === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rf_rd !== e.rd || rf_wd !== e.wd) begin
        miscompares++; $display("[TB] FAIL same_write got x%0d=%h want x%0d=%h", rf_rd, rf_wd, e.rd, e.wd);
      end
    end else begin
      vectors++; miscompares++; $display("[TB] FAIL same_we got %b want 1", rf_we);
    end
    @(negedge clk);
    mdu_issue = 1'b0; mdu_issue_rd = '0; mdu_data = 32'h78;
    exp_q.push_back('{rd: 5'd7, wd: 32'h78});
    #1;
    vectors++; if (busy_vec !== 32'h80) begin miscompares++; $display("[TB] FAIL same_busy_kept got %h want 00000080", busy_vec); end
    if (rf_we === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (rf_rd !== e.rd || rf_wd !== e.wd) begin
        miscompares++; $display("[TB] FAIL same_write2 got x%0d=%h want x%0d=%h", rf_rd, rf_wd, e.rd, e.wd);
      end
    end else begin
      vectors++; miscompares++; $display("[TB] FAIL same_we2 got %b want 1", rf_we);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("[TB] FAIL same_busy_clear got %h want 0", busy_vec); end
  endtask

  // Asynchronous reset while in FORCE_MDU with x5 and x7 busy.
  task automatic test_reset_in_force();
    @(negedge clk);
    mdu_issue = 1'b1; mdu_issue_rd = 5'd5;
    @(negedge clk);
    mdu_issue_rd = 5'd7;
    @(negedge clk);
    mdu_issue = 1'b0; mdu_issue_rd = '0;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hCC;
    repeat (4) @(negedge clk);
    #1;
    vectors++; if (stall !== 1'b1 || mdu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL force_entry stall=%b ready=%b want 1/1", stall, mdu_ready); end
    vectors++; if (busy_vec !== 32'hA0) begin miscompares++; $display("[TB] FAIL force_busy got %h want 000000a0", busy_vec); end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("[TB] FAIL arst_busy got %h want 0", busy_vec); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_we got %b want 0", rf_we); end
    vectors++; if (stall !== 1'b0 || mdu_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL arst_stall_ready got %b/%b want 0/0", stall, mdu_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || stall !== 1'b0) begin
      miscompares++; $display("[TB] FAIL post_arst_normal got we=%b rd=%0d stall=%b want 1/9/0", rf_we, rf_rd, stall);
    end
    idle_inputs();
  endtask

  // MDU result to x0: acknowledged with no write and no scoreboard change.
  task automatic test_mdu_rd0();
    @(negedge clk);
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hDEAD;
    #1;
    vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rd0_ready got %b want 1", mdu_ready); end
    vectors++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'h0) begin
      miscompares++; $display("[TB] FAIL rd0_port got we=%b x%0d=%h want 0/x0=0", rf_we, rf_rd, rf_wd);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("[TB] FAIL rd0_busy got %h want 0", busy_vec); end
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_hazard();
    test_starvation();
    test_same_cycle();
    test_reset_in_force();
    test_mdu_rd0();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("[TB] FAIL leftover_writes got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
